tdm_spike_encoder: RTL and testbench



---
 rtl/tdm_pkg.sv | 18 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/tdm_spike_encoder.sv | 120 ++++++++++++
 tb/tb_tdm_spike_encoder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM neuron pipeline: default widths, spike threshold,
// and the address-event payload type.
package tdm_pkg;

    localparam int unsigned NEURON_COUNT_DEF = 500;
    localparam int unsigned DATA_WIDTH_DEF   = 16;
    localparam int unsigned TS_W_DEF         = 16;
    localparam int unsigned ID_W_DEF         = $clog2(NEURON_COUNT_DEF);

    // Roughly +30 mV in the membrane-state fixed-point scale.
    localparam logic signed [DATA_WIDTH_DEF-1:0] SPIKE_THRESH_DEF = 16'sd2259;

    typedef struct packed {
        logic [ID_W_DEF-1:0] id;
        logic [TS_W_DEF-1:0] ts;
    } aer_event_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// A push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the output is qualified by empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/tdm_spike_encoder.sv
// Threshold spike detector on the TDM write-back stream, emitting AER events via a FIFO.
// Define SPIKE_ENC_EDGE_EN to fire only on rising threshold crossings per neuron.
module tdm_spike_encoder
    import tdm_pkg::*;
#(
    parameter int unsigned                    NEURON_COUNT = NEURON_COUNT_DEF,
    parameter int unsigned                    DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter logic signed [DATA_WIDTH-1:0]   SPIKE_THRESH = SPIKE_THRESH_DEF,
    parameter int unsigned                    FIFO_DEPTH   = 16,
    parameter int unsigned                    TS_W         = TS_W_DEF,
    localparam int unsigned                   ID_W         = $clog2(NEURON_COUNT)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [ID_W-1:0]                in_id,
    input  logic signed [DATA_WIDTH-1:0]   in_v,
    output logic                           aer_valid,
    input  logic                           aer_ready,
    output logic [ID_W-1:0]                aer_id,
    output logic [TS_W-1:0]                aer_ts,
    output logic [TS_W-1:0]                ts_count,
    output logic [15:0]                    drop_count,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

    logic            hit, last_slot, spike_event;
    logic            s1_hit_q, s1_hit_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic [TS_W-1:0] s1_ts_q, s1_ts_d;
    logic [TS_W-1:0] ts_count_q, ts_count_d;
    logic [15:0]     drop_count_q, drop_count_d;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ID_W+TS_W-1:0] fifo_rdata;

    assign hit       = in_valid && (in_v >= SPIKE_THRESH);
    assign last_slot = in_valid && (in_id == ID_W'(NEURON_COUNT - 1));

`ifdef SPIKE_ENC_EDGE_EN
    logic [NEURON_COUNT-1:0] flag_q, flag_d;
    logic                    in_range;

    assign in_range = (32'(in_id) < NEURON_COUNT);

    // Out-of-range ids have no flag and behave level-sensitively.
    always_comb begin
        flag_d      = flag_q;
        spike_event = hit && !(in_range && flag_q[in_id]);
        if (in_valid && in_range) begin
            flag_d[in_id] = hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= '0;
        end else begin
            flag_q <= flag_d;
        end
    end
`else
    assign spike_event = hit;
`endif

    assign fifo_pop  = !fifo_empty && aer_ready;
    assign fifo_push = s1_hit_q && (!fifo_full || fifo_pop);

    always_comb begin
        s1_hit_d     = spike_event;
        s1_id_d      = in_id;
        s1_ts_d      = ts_count_q;
        ts_count_d   = ts_count_q;
        drop_count_d = drop_count_q;
        if (last_slot) begin
            ts_count_d = ts_count_q + TS_W'(1);
        end
        if (s1_hit_q && !fifo_push && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hit_q     <= 1'b0;
            s1_id_q      <= '0;
            s1_ts_q      <= '0;
            ts_count_q   <= '0;
            drop_count_q <= '0;
        end else begin
            s1_hit_q     <= s1_hit_d;
            s1_id_q      <= s1_id_d;
            s1_ts_q      <= s1_ts_d;
            ts_count_q   <= ts_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    sync_fifo #(
        .WIDTH (ID_W + TS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({s1_id_q, s1_ts_q}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Payload reads as zero while no event is held.
    assign aer_valid  = !fifo_empty;
    assign aer_id     = fifo_empty ? '0 : fifo_rdata[TS_W +: ID_W];
    assign aer_ts     = fifo_empty ? '0 : fifo_rdata[TS_W-1:0];
    assign ts_count   = ts_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_tdm_spike_encoder.sv
// Directed bench for tdm_spike_encoder with a queue scoreboard of expected AER events.
module tb_tdm_spike_encoder;
    import tdm_pkg::*;

`ifdef SPIKE_ENC_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [8:0]         in_id;
    logic signed [15:0] in_v;
    logic               aer_valid;
    logic               aer_ready;
    logic [8:0]         aer_id;
    logic [15:0]        aer_ts;
    logic [15:0]        ts_count;
    logic [15:0]        drop_count;
    logic [4:0]         fifo_level;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    int p0;
    aer_event_t sb[$];
    aer_event_t mon_e;

    always #5 clk = ~clk;

    tdm_spike_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_id      (in_id),
        .in_v       (in_v),
        .aer_valid  (aer_valid),
        .aer_ready  (aer_ready),
        .aer_id     (aer_id),
        .aer_ts     (aer_ts),
        .ts_count   (ts_count),
        .drop_count (drop_count),
        .fifo_level (fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input logic [8:0] id, input logic signed [15:0] v);
        in_valid = 1'b1;
        in_id    = id;
        in_v     = v;
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_id    = '0;
        in_v     = '0;
        repeat (n) step();
    endtask

    task automatic expect_ev(input logic [8:0] id, input logic [15:0] ts);
        aer_event_t e;
        e.id = id;
        e.ts = ts;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && sb.size() != 0; i++) step();
        chk(tag, sb.size(), 0);
    endtask

    // Every accepted handshake is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && aer_valid && aer_ready) begin
            pops++;
            chk("event_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("aer_id", 32'(aer_id), 32'(mon_e.id));
                chk("aer_ts", 32'(aer_ts), 32'(mon_e.ts));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_id     = '0;
        in_v      = '0;
        aer_ready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_aer_valid", 32'(aer_valid), 0);
        chk("rst_aer_id", 32'(aer_id), 0);
        chk("rst_aer_ts", 32'(aer_ts), 0);
        chk("rst_ts_count", 32'(ts_count), 0);
        chk("rst_drop_count", 32'(drop_count), 0);
        chk("rst_fifo_level", 32'(fifo_level), 0);
        step();
        rst = 1'b0;

        // Single spike at exactly the threshold: visible after the second edge.
        aer_ready = 1'b1;
        expect_ev(9'd7, 16'd0);
        slot(9'd7, 16'sd2259);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_s1_only", 32'(aer_valid), 0);
        step();
        @(negedge clk);
        chk("lat_valid", 32'(aer_valid), 1);
        chk("lat_id", 32'(aer_id), 7);
        chk("lat_ts", 32'(aer_ts), 0);
        step();
        idle(1);

        // One below threshold: no event.
        p0 = pops;
        slot(9'd7, 16'sd2258);
        idle(4);
        chk("below_thresh_events", pops - p0, 0);
        chk("below_thresh_level", 32'(fifo_level), 0);

        // Three frames with a spike on the last slot.
        for (int f = 0; f < 3; f++) begin
            for (int id = 0; id < 500; id++) begin
                if (id == 499 && (!EDGE || f == 0)) expect_ev(9'd499, 16'(f));
                slot(9'(id), (id == 499) ? 16'sd3000 : -16'sd100);
            end
        end
        idle(3);
        chk("frame_ts_count", 32'(ts_count), 3);
        drain("frame_drain");

        // Id beyond the frame is encoded but does not advance the frame counter.
        expect_ev(9'd505, 16'd3);
        slot(9'd505, 16'sd3000);
        idle(4);
        chk("oor_ts_count", 32'(ts_count), 3);
        drain("oor_drain");

        // Backpressure: 20 spikes into a 16-deep FIFO.
        aer_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) expect_ev(9'(10 + i), 16'd3);
            slot(9'(10 + i), 16'(2259 + i));
        end
        idle(2);
        @(negedge clk);
        chk("bp_level", 32'(fifo_level), 16);
        chk("bp_drops", 32'(drop_count), 4);
        chk("bp_valid", 32'(aer_valid), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("stall_id", 32'(aer_id), 32'(sb[0].id));
            chk("stall_ts", 32'(aer_ts), 32'(sb[0].ts));
        end
        step();

        // Full FIFO with a pop and a push on the same edge.
        expect_ev(9'd40, 16'd3);
        slot(9'd40, 16'sd3000);
        in_valid  = 1'b0;
        aer_ready = 1'b1;
        step();
        aer_ready = 1'b0;
        @(negedge clk);
        chk("full_pop_level", 32'(fifo_level), 16);
        chk("full_pop_drops", 32'(drop_count), 4);
        step();

        p0 = pops;
        aer_ready = 1'b1;
        drain("bp_drain");
        chk("bp_release_count", pops - p0, 16);
        @(negedge clk);
        chk("bp_empty_level", 32'(fifo_level), 0);
        step();

        // Reset with events queued.
        aer_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_ev(9'(50 + i), 16'd3);
            slot(9'(50 + i), 16'sd3000);
        end
        idle(2);
        @(negedge clk);
        chk("pre_rst_level", 32'(fifo_level), 5);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_valid", 32'(aer_valid), 0);
        chk("mid_rst_level", 32'(fifo_level), 0);
        chk("mid_rst_ts_count", 32'(ts_count), 0);
        chk("mid_rst_drops", 32'(drop_count), 0);
        step();

        // Held above threshold, one dip, then above again.
        aer_ready = 1'b1;
        p0 = pops;
        expect_ev(9'd3, 16'd0);
        if (!EDGE) begin
            expect_ev(9'd3, 16'd0);
            expect_ev(9'd3, 16'd0);
        end
        expect_ev(9'd3, 16'd0);
        slot(9'd3, 16'sd3000);
        slot(9'd3, 16'sd3000);
        slot(9'd3, 16'sd3000);
        slot(9'd3, 16'sd100);
        slot(9'd3, 16'sd3000);
        idle(3);
        drain("mode_drain");
        chk("mode_event_count", pops - p0, EDGE ? 2 : 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
